bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_if.sv | 11 +
 rtl/bus_arbiter_hold_timer.sv | 36 +++
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM encodings,
// hold-time default and requester indices.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        GRANT = 2'h1,
        TURN  = 2'h2
    } arb_state_e;

    localparam int MAX_HOLD_DEFAULT = 16;
    localparam int NUM_REQ          = 2;

    localparam logic ENC  = 1'b0;
    localparam logic HOST = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface bus_arbiter_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic       owner;
    logic       busy;
    logic       preempt;

    modport master (output req, input grant, input owner, input busy, input preempt);
    modport slave  (input req, output grant, output owner, output busy, output preempt);
endinterface

// File: rtl/bus_arbiter_hold_timer.sv
// Saturating count of consecutive grant cycles; expired marks the last allowed cycle.
module hold_timer #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] count,
    output logic       expired
);
    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    logic [4:0] count_q;
    logic [4:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 5'd0;
        end else if (enable && (count_q != HOLD_LAST)) begin
            count_d = count_q + 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 5'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == HOLD_LAST);
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two bus masters with a one-cycle turnaround after
// every grant and hold-time preemption when the other side is waiting.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    bus_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;
    logic       last_owner_q, last_owner_d;

    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;
    logic [4:0] unused_hold_count;

    logic       winner;
    logic [1:0] win_onehot;

    // On contention the side that did not hold the bus last goes first.
    assign winner = (bus.req == 2'b11) ? ~last_owner_q : bus.req[HOST];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (winner == 1'(gi));
    end

    hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .count   (unused_hold_count),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        preempt_d    = 1'b0;
        last_owner_d = last_owner_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                if (bus.req != 2'b00) begin
                    state_d      = GRANT;
                    grant_d      = win_onehot;
                    busy_d       = 1'b1;
                    last_owner_d = winner;
                    timer_clear  = 1'b1;
                end
            end
            GRANT: begin
                timer_enable = 1'b1;
                // A release wins over a simultaneous preemption, so check it first.
                if (!bus.req[last_owner_q]) begin
                    state_d = TURN;
                    grant_d = 2'b00;
                end else if (timer_expired && bus.req[~last_owner_q]) begin
                    state_d   = TURN;
                    grant_d   = 2'b00;
                    preempt_d = 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            preempt_q    <= 1'b0;
            last_owner_q <= HOST;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            preempt_q    <= preempt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
    assign bus.owner   = last_owner_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a cycle model pushes expected outputs as
// each request vector is driven; each scenario pops and compares after the edge.
module tb_bus_arbiter;
    localparam int MAX_HOLD = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 idle, 1 granted, 2 turnaround; m_held counts grant cycles so far.
    int         m_state = 0;
    int         m_held  = 0;
    logic       m_owner = 1'b1;
    logic [1:0] m_grant = 2'b00;
    logic       m_busy  = 1'b0;
    logic       m_pre   = 1'b0;
    logic [4:0] exp_q[$];

    task automatic drive_cycle(input logic [1:0] r);
        bus.req = r;
        m_pre = 1'b0;
        if (reset) begin
            m_state = 0; m_held = 0; m_owner = 1'b1; m_grant = 2'b00; m_busy = 1'b0;
        end else if (m_state == 0) begin
            if (r != 2'b00) begin
                m_owner = (r == 2'b11) ? !m_owner : (r == 2'b10);
                m_grant = m_owner ? 2'b10 : 2'b01;
                m_busy  = 1'b1; m_held = 1; m_state = 1;
            end else begin
                m_grant = 2'b00; m_busy = 1'b0;
            end
        end else if (m_state == 1) begin
            if (!r[m_owner]) begin
                m_state = 2; m_grant = 2'b00;
            end else if (m_held >= MAX_HOLD && r[!m_owner]) begin
                m_state = 2; m_grant = 2'b00; m_pre = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end else begin
            m_state = 0; m_grant = 2'b00; m_busy = 1'b0;
        end
        exp_q.push_back({m_grant, m_busy, m_pre, m_owner});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp_v, got_v;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(2'b11);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_reset cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
        end
        checks++;
        if (dut.u_hold_timer.count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", dut.u_hold_timer.count);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_enc();
        logic [4:0] exp_v, got_v;
        logic [1:0] r;
        for (int i = 0; i < 10; i++) begin
            r = (i < 5) ? 2'b01 : 2'b00;
            drive_cycle(r);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_single_enc cyc=%0d req=%b got=%b exp=%b", i, r, got_v, exp_v);
            end
        end
    endtask

    task automatic test_preempt();
        logic [4:0] exp_v, got_v;
        int first_pre;
        logic [1:0] grant18;
        first_pre = -1;
        grant18   = 2'b00;
        test_reset();
        for (int i = 0; i < 24; i++) begin
            drive_cycle(2'b11);
            if (bus.preempt && first_pre < 0) first_pre = i;
            if (i == 18) grant18 = bus.grant;
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_preempt cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
        end
        checks++;
        if (first_pre != MAX_HOLD) begin
            failures++;
            $display("FAIL preempt_cycle got=%0d exp=%0d", first_pre, MAX_HOLD);
        end
        checks++;
        if (grant18 !== 2'b10) begin
            failures++;
            $display("FAIL preempt_handover got=%b exp=10", grant18);
        end
    endtask

    task automatic test_saturation();
        logic [4:0] exp_v, got_v;
        int pre_seen;
        pre_seen = 0;
        test_reset();
        for (int i = 0; i < 40; i++) begin
            drive_cycle(2'b10);
            if (bus.preempt) pre_seen++;
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_saturation cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
        end
        checks++;
        if (dut.u_hold_timer.count !== 5'(MAX_HOLD - 1)) begin
            failures++;
            $display("FAIL hold_saturate got=%0d exp=%0d", dut.u_hold_timer.count, MAX_HOLD - 1);
        end
        checks++;
        if (pre_seen != 0) begin
            failures++;
            $display("FAIL saturate_no_preempt got=%0d exp=0", pre_seen);
        end
    endtask

    task automatic test_release_at_expiry();
        logic [4:0] exp_v, got_v;
        logic [1:0] r;
        test_reset();
        for (int i = 0; i < 22; i++) begin
            r = (i < MAX_HOLD) ? 2'b11 : 2'b10;
            drive_cycle(r);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_release_at_expiry cyc=%0d req=%b got=%b exp=%b", i, r, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [4:0] exp_v, got_v;
        logic [1:0] r;
        test_reset();
        for (int i = 0; i < 10; i++) begin
            reset = (i == 5);
            r = (i < 5) ? 2'b10 : 2'b11;
            drive_cycle(r);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_reset_mid_grant cyc=%0d req=%b got=%b exp=%b", i, r, got_v, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_glitches();
        logic [4:0] exp_v, got_v;
        logic [1:0] seq [8] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
        test_reset();
        // Short pulse between edges while idle must never be sampled.
        bus.req = 2'b01;
        #2;
        bus.req = 2'b00;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(seq[i]);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_glitches cyc=%0d req=%b got=%b exp=%b", i, seq[i], got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_v, got_v;
        logic [1:0] r, prev_grant;
        r = 2'b00;
        prev_grant = 2'b00;
        test_reset();
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 2'($urandom_range(0, 3));
            drive_cycle(r);
            exp_v = exp_q.pop_front();
            got_v = {bus.grant, bus.busy, bus.preempt, bus.owner};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL test_random cyc=%0d req=%b got=%b exp=%b", i, r, got_v, exp_v);
            end
            checks++;
            if (bus.grant === 2'b11) begin
                failures++;
                $display("FAIL random_onehot cyc=%0d got=%b exp=not 11", i, bus.grant);
            end
            checks++;
            if (bus.grant != 2'b00 && prev_grant != 2'b00 && bus.grant != prev_grant) begin
                failures++;
                $display("FAIL random_gap cyc=%0d got=%b prev=%b exp=zero cycle between owners", i, bus.grant, prev_grant);
            end
            prev_grant = bus.grant;
        end
    endtask

    initial begin
        bus.req = 2'b00;
        test_reset();
        test_single_enc();
        test_preempt();
        test_saturation();
        test_release_at_expiry();
        test_reset_mid_grant();
        test_glitches();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
